mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the core's single external memory port between the L1 instruction cache refill path and the data path (load/store unit or data cache).
- Instruction refills are fixed-length line bursts of `IBURST` words; data accesses are single-word reads or byte-masked writes.
- When both sides are waiting, grants alternate round-robin.
- A granted transaction holds the port until it completes or times out.
- Sits between the core's memory-side interfaces and the system memory controller; with the L2 cache disabled it is the only path to memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: word width. Byte-enable width is `DATA_WIDTH/8`.
- `IBURST`, default 4: words per instruction line. Power of two, ≥ 1. Tied to the core config's instruction-cache block count.
- `TIMEOUT`, default 255: cycles to wait for `i_mem_ack` before aborting. 0 disables the timeout.

Ports (signal, direction, width, meaning):
- `i_clock`, in, 1: clock.
- `i_reset`, in, 1: reset. Synchronous, active-high.
- `i_ibus_req`, in, 1: instruction line refill request. Held until `o_ibus_last` or `o_ibus_err`.
- `i_ibus_addr`, in, `ADDR_WIDTH`: any address inside the requested line.
- `o_ibus_rvalid`, out, 1: beat valid.
- `o_ibus_rdata`, out, `DATA_WIDTH`: beat data.
- `o_ibus_beat`, out, clog2(`IBURST`) (minimum 1): index of the current beat.
- `o_ibus_last`, out, 1: final beat of the line.
- `o_ibus_err`, out, 1: the refill timed out.
- `i_dbus_req`, in, 1: data access request. Held until `o_dbus_done` or `o_dbus_err`.
- `i_dbus_we`, in, 1: write enable.
- `i_dbus_be`, in, `DATA_WIDTH/8`: byte enables.
- `i_dbus_addr`, in, `ADDR_WIDTH`: access address.
- `i_dbus_wdata`, in, `DATA_WIDTH`: write data.
- `o_dbus_done`, out, 1: access complete.
- `o_dbus_rdata`, out, `DATA_WIDTH`: read data.
- `o_dbus_err`, out, 1: the access timed out.
- `o_mem_req`, out, 1: memory request.
- `o_mem_we`, out, 1: memory write enable.
- `o_mem_be`, out, `DATA_WIDTH/8`: memory byte enables.
- `o_mem_addr`, out, `ADDR_WIDTH`: memory address.
- `o_mem_wdata`, out, `DATA_WIDTH`: memory write data.
- `i_mem_ack`, in, 1: memory acknowledge. Accepts the beat and returns read data in the same cycle.
- `i_mem_rdata`, in, `DATA_WIDTH`: memory read data, valid with `i_mem_ack`.

## Operation
FSM states and transitions:
- **IDLE**
  - Only `i_ibus_req`: go to IFETCH.
  - Only `i_dbus_req`: go to DACCESS.
  - Both: grant the side not served last (`last_grant` flag). Reset value of the flag is IBUS, so data wins the first tie.
- **IFETCH**
  - At grant, capture the line base: `i_ibus_addr` with the low clog2(`IBURST`)+clog2(`DATA_WIDTH/8`) bits cleared. Reset beat counter to 0.
  - `o_mem_addr` = base + beat × (`DATA_WIDTH/8`); `o_mem_we` = 0; `o_mem_be` = all ones.
  - Each `i_mem_ack`: `o_ibus_rvalid` = 1, `o_ibus_rdata` = `i_mem_rdata` (combinational pass-through), `o_ibus_beat` = counter; then counter increments.
  - On the ack with counter = `IBURST`−1: `o_ibus_last` = 1, go to IDLE, `last_grant` ← IBUS.
- **DACCESS**
  - At grant, capture `we`/`be`/`addr`/`wdata` from the data side and drive them on the `o_mem_*` outputs.
  - On `i_mem_ack`: `o_dbus_done` = 1, `o_dbus_rdata` = `i_mem_rdata` (don't-care for writes), go to IDLE, `last_grant` ← DBUS.

Timeout:
- The wait counter clears on every ack and on every grant, and increments each cycle `o_mem_req` is high without `i_mem_ack`.
- When it reaches `TIMEOUT` (with `TIMEOUT` > 0): one-cycle pulse on the active side's `_err`, go to IDLE, `last_grant` updated as for completion.

Boundary conditions:
- `i_mem_ack` while in IDLE is ignored.
- `i_mem_ack` on the same cycle the timeout fires: the ack wins and no error is raised.
- A requester must drop `req` on the cycle after `done`/`last`/`err`. If `req` is still high in IDLE, it is treated as a new request.
- Request inputs are sampled only in IDLE; changes to them mid-transaction are ignored.
- `i_reset` mid-transaction: go to IDLE immediately and abandon the transaction. The memory controller must tolerate `o_mem_req` dropping without an ack.

Reset values:
- All outputs 0, state IDLE, beat and wait counters 0, `last_grant` = IBUS.

## Timing
- Requests seen in IDLE at cycle N produce `o_mem_req` = 1 at N+1. All `o_mem_*` outputs are registered and held stable until ack.
- `o_mem_req` stays high across consecutive beats of a burst. Zero-wait memory gives one beat per cycle.
- Each transaction ends with one IDLE cycle: after the final ack at cycle M, the next `o_mem_req` is at M+2 at the earliest.
- Response outputs are single-cycle pulses aligned to the ack cycle.
- Minimum latencies with a zero-wait memory (request → final response): data access 2 cycles; refill `IBURST`+1 cycles.

## Structure
- Arbiter state enum and the `last_grant` encoding go in the shared core definitions package.
- `IBURST` is bound from the core config's instruction-cache block count at instantiation; it is not hard-coded.
- One sub-module: `arbiter_rr2`, a two-requester round-robin granter holding `last_grant`. It takes the two request lines plus a "grant consumed" strobe and returns a one-hot grant.
- Beat counter, wait counter and FSM live in `mem_bus_arbiter`.

## Test plan
- Single data write, `addr` 0x100, `be` 0b0011, `wdata` 0xDEADBEEF, ack after 2 wait cycles → `o_mem_*` match the inputs and stay stable for 3 cycles; `o_dbus_done` pulses on the ack cycle.
- Refill with `i_ibus_addr` 0x1234 and `IBURST` = 4, zero-wait memory → `o_mem_addr` sequence 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; `o_ibus_beat` 0..3; `o_ibus_last` only on beat 3.
- Both requests high continuously from reset → grant order DBUS, IBUS, DBUS, IBUS; one IDLE cycle between transactions.
- `TIMEOUT` = 8, memory never acks a data read → `o_dbus_err` pulses exactly 8 cycles after `o_mem_req` rises; FSM returns to IDLE and serves a pending `i_ibus_req` next.
- `i_reset` asserted during beat 2 of a refill → next cycle all outputs are 0 and state is IDLE; a fresh refill then restarts from beat 0.
- `i_mem_ack` asserted while IDLE, and ack coinciding with the timeout cycle → the first is ignored with no response pulses; the second completes normally with no `_err`.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
// Line size comes from the core's instruction-cache configuration.
package mem_bus_arbiter_pkg;

    localparam int ICACHE_BLOCK_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IFETCH,
        ST_DACCESS
    } arb_state_e;

    typedef enum logic {
        GNT_IBUS = 1'b0,
        GNT_DBUS = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-requester round-robin granter; remembers the side granted last.
// Grant bit 0 is the instruction side, bit 1 the data side.
module arbiter_rr2
    import mem_bus_arbiter_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_req_ibus,
    input  logic       i_req_dbus,
    input  logic       i_consume,
    output logic [1:0] o_grant
);

    grant_e last_grant_q, last_grant_d;
    logic   ibus_win, dbus_win;

    always_comb begin
        ibus_win     = i_req_ibus && (!i_req_dbus || last_grant_q == GNT_DBUS);
        dbus_win     = i_req_dbus && (!i_req_ibus || last_grant_q == GNT_IBUS);
        o_grant      = {dbus_win, ibus_win};
        last_grant_d = last_grant_q;
        // The granted side is the one the next transaction completes for.
        if (i_consume)
            last_grant_d = dbus_win ? GNT_DBUS : GNT_IBUS;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            last_grant_q <= GNT_IBUS;
        else
            last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between I-cache line refills (bursts)
// and single-word data accesses, with round-robin arbitration and timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int IBURST     = ICACHE_BLOCK_WORDS,
    parameter  int TIMEOUT    = 255,
    localparam int BE_W       = DATA_WIDTH / 8,
    localparam int BEAT_W     = (IBURST > 1) ? $clog2(IBURST) : 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_ibus_req,
    input  logic [ADDR_WIDTH-1:0] i_ibus_addr,
    output logic                  o_ibus_rvalid,
    output logic [DATA_WIDTH-1:0] o_ibus_rdata,
    output logic [BEAT_W-1:0]     o_ibus_beat,
    output logic                  o_ibus_last,
    output logic                  o_ibus_err,
    input  logic                  i_dbus_req,
    input  logic                  i_dbus_we,
    input  logic [BE_W-1:0]       i_dbus_be,
    input  logic [ADDR_WIDTH-1:0] i_dbus_addr,
    input  logic [DATA_WIDTH-1:0] i_dbus_wdata,
    output logic                  o_dbus_done,
    output logic [DATA_WIDTH-1:0] o_dbus_rdata,
    output logic                  o_dbus_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [BE_W-1:0]       o_mem_be,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int WAIT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LINE_OFF = $clog2(IBURST) + $clog2(BE_W);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << LINE_OFF) - ADDR_WIDTH'(1));
    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(BE_W);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(IBURST - 1);

    arb_state_e            state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [BE_W-1:0]       mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]            grant;
    logic                  consume;
    logic                  timeout_hit;

    arbiter_rr2 u_rr (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_req_ibus (i_ibus_req),
        .i_req_dbus (i_dbus_req),
        .i_consume  (consume),
        .o_grant    (grant)
    );

    // An ack in the same cycle overrides the timeout (checked ahead of it below).
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT));

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        wait_d        = wait_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_be_d      = mem_be_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        consume       = 1'b0;
        o_ibus_rvalid = 1'b0;
        o_ibus_rdata  = '0;
        o_ibus_beat   = '0;
        o_ibus_last   = 1'b0;
        o_ibus_err    = 1'b0;
        o_dbus_done   = 1'b0;
        o_dbus_rdata  = '0;
        o_dbus_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                wait_d = '0;
                if (grant[0]) begin
                    consume    = 1'b1;
                    state_d    = ST_IFETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = '1;
                    mem_addr_d = i_ibus_addr & LINE_MASK;
                    mem_wdata_d = '0;
                end else if (grant[1]) begin
                    consume     = 1'b1;
                    state_d     = ST_DACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = i_dbus_we;
                    mem_be_d    = i_dbus_be;
                    mem_addr_d  = i_dbus_addr;
                    mem_wdata_d = i_dbus_wdata;
                end
            end
            ST_IFETCH: begin
                if (i_mem_ack) begin
                    o_ibus_rvalid = 1'b1;
                    o_ibus_rdata  = i_mem_rdata;
                    o_ibus_beat   = beat_q;
                    wait_d        = '0;
                    if (beat_q == LAST_BEAT) begin
                        o_ibus_last = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        beat_d     = beat_q + BEAT_W'(1);
                        mem_addr_d = mem_addr_q + BEAT_STEP;
                    end
                end else if (timeout_hit) begin
                    o_ibus_err = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wait_d = (TIMEOUT != 0) ? wait_q + WAIT_W'(1) : '0;
                end
            end
            ST_DACCESS: begin
                if (i_mem_ack) begin
                    o_dbus_done  = 1'b1;
                    o_dbus_rdata = i_mem_rdata;
                    state_d      = ST_IDLE;
                end else if (timeout_hit) begin
                    o_dbus_err = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wait_d = (TIMEOUT != 0) ? wait_q + WAIT_W'(1) : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every path back to IDLE parks the memory port at zero.
        if (state_d == ST_IDLE) begin
            beat_d      = '0;
            wait_d      = '0;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_be_d    = '0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_be    = mem_be_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of expected memory beats.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IB = 4;
    localparam int TO = 8;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_ibus_req;
    logic [AW-1:0] i_ibus_addr;
    logic          o_ibus_rvalid;
    logic [DW-1:0] o_ibus_rdata;
    logic [1:0]    o_ibus_beat;
    logic          o_ibus_last;
    logic          o_ibus_err;
    logic          i_dbus_req;
    logic          i_dbus_we;
    logic [3:0]    i_dbus_be;
    logic [AW-1:0] i_dbus_addr;
    logic [DW-1:0] i_dbus_wdata;
    logic          o_dbus_done;
    logic [DW-1:0] o_dbus_rdata;
    logic          o_dbus_err;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [3:0]    o_mem_be;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IBURST(IB), .TIMEOUT(TO)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_ibus_req(i_ibus_req), .i_ibus_addr(i_ibus_addr),
        .o_ibus_rvalid(o_ibus_rvalid), .o_ibus_rdata(o_ibus_rdata), .o_ibus_beat(o_ibus_beat),
        .o_ibus_last(o_ibus_last), .o_ibus_err(o_ibus_err),
        .i_dbus_req(i_dbus_req), .i_dbus_we(i_dbus_we), .i_dbus_be(i_dbus_be),
        .i_dbus_addr(i_dbus_addr), .i_dbus_wdata(i_dbus_wdata),
        .o_dbus_done(o_dbus_done), .o_dbus_rdata(o_dbus_rdata), .o_dbus_err(o_dbus_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clock = ~i_clock;

    logic [140:0] all_out;
    logic [5:0]   pulses;
    assign all_out = {o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_ibus_rvalid,
                      o_ibus_rdata, o_ibus_beat, o_ibus_last, o_ibus_err, o_dbus_done,
                      o_dbus_rdata, o_dbus_err};
    assign pulses  = {o_mem_req, o_ibus_rvalid, o_ibus_last, o_ibus_err, o_dbus_done, o_dbus_err};

    typedef struct {
        bit          is_i;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wd;
        int          beat;
        bit          last;
    } beat_t;

    beat_t q[$];
    bit    last_i = 1'b1;   // side served last; instruction side after reset
    int    vecs = 0;
    int    errs = 0;

    function automatic int wait_for(input bit is_i, input int iw, input int dw);
        int w, r;
        w = is_i ? iw : dw;
        if (w >= 0) return w;
        r = $urandom_range(0, 11);
        if (r < 8) return r % 4;
        return (r < 10) ? TO : 20;
    endfunction

    // One arbitration round: the chosen sides request together, the bench acts
    // as memory, and every cycle is compared against the expected beat queue.
    task automatic do_round(input bit ri, input bit rd, input logic [31:0] ia,
                            input logic [31:0] da, input bit dwe, input logic [3:0] dbe,
                            input logic [31:0] dwd, input int iw, input int dw);
        beat_t h;
        bit first_i, side_i, exp_req, hit, tmo, drop_i, drop_d;
        int gap, waited, tgt, guard;
        q.delete();
        first_i = ri && (!rd || !last_i);
        for (int s = 0; s < 2; s++) begin
            side_i = (s == 0) ? first_i : !first_i;
            if (side_i && ri) begin
                for (int k = 0; k < IB; k++)
                    q.push_back('{1'b1, (ia & ~32'hF) + 32'(4 * k), 1'b0, 4'hF, 32'h0, k, k == IB - 1});
            end else if (!side_i && rd) begin
                q.push_back('{1'b0, da, dwe, dbe, dwd, 0, 1'b1});
            end
        end
        gap = 1; waited = 0; guard = 0; drop_i = 0; drop_d = 0;
        tgt = (q.size() > 0) ? wait_for(q[0].is_i, iw, dw) : 0;
        h = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b0};
        i_ibus_addr = ia; i_dbus_addr = da; i_dbus_we = dwe; i_dbus_be = dbe; i_dbus_wdata = dwd;
        do begin
            @(negedge i_clock);
            i_ibus_req = ri && !drop_i;
            i_dbus_req = rd && !drop_d;
            exp_req = (q.size() > 0) && (gap == 0);
            if (exp_req) begin
                h = q[0];
                // inputs of the side being served must be ignored until it finishes
                if ($urandom_range(0, 1) == 1) begin
                    if (h.is_i) i_ibus_addr = $urandom;
                    else begin i_dbus_addr = $urandom; i_dbus_wdata = $urandom; end
                end
            end
            i_mem_ack   = exp_req ? (waited == tgt) : 1'($urandom_range(0, 1));
            i_mem_rdata = $urandom;
            #1;
            hit = exp_req && i_mem_ack;
            tmo = exp_req && !i_mem_ack && (waited == TO);
            vecs++;
            if (o_mem_req !== exp_req) begin
                errs++; $display("FAIL mem_req: got %b want %b at %0t", o_mem_req, exp_req, $time);
            end
            if (exp_req) begin
                vecs++;
                if ({o_mem_addr, o_mem_we, o_mem_be} !== {h.addr, h.we, h.be}) begin
                    errs++;
                    $display("FAIL mem_cmd: got addr=%h we=%b be=%h want addr=%h we=%b be=%h",
                             o_mem_addr, o_mem_we, o_mem_be, h.addr, h.we, h.be);
                end
                if (!h.is_i) begin
                    vecs++;
                    if (o_mem_wdata !== h.wd) begin
                        errs++; $display("FAIL mem_wdata: got %h want %h", o_mem_wdata, h.wd);
                    end
                end
            end
            vecs++;
            if ({o_ibus_rvalid, o_ibus_last, o_ibus_err} !==
                {hit && h.is_i, hit && h.is_i && h.last, tmo && h.is_i}) begin
                errs++;
                $display("FAIL ibus_resp: got rvalid/last/err=%b%b%b want %b%b%b at %0t",
                         o_ibus_rvalid, o_ibus_last, o_ibus_err,
                         hit && h.is_i, hit && h.is_i && h.last, tmo && h.is_i, $time);
            end
            vecs++;
            if ({o_dbus_done, o_dbus_err} !== {hit && !h.is_i, tmo && !h.is_i}) begin
                errs++;
                $display("FAIL dbus_resp: got done/err=%b%b want %b%b at %0t",
                         o_dbus_done, o_dbus_err, hit && !h.is_i, tmo && !h.is_i, $time);
            end
            if (hit) begin
                vecs++;
                if (h.is_i ? ({o_ibus_rdata, o_ibus_beat} !== {i_mem_rdata, 2'(h.beat)})
                           : (o_dbus_rdata !== i_mem_rdata)) begin
                    errs++;
                    $display("FAIL rdata: got i=%h beat=%0d d=%h want data %h beat %0d",
                             o_ibus_rdata, o_ibus_beat, o_dbus_rdata, i_mem_rdata, h.beat);
                end
            end
            if (gap > 0) gap--;
            if (hit || tmo) begin
                waited = 0;
                if (hit) void'(q.pop_front());
                if (tmo) while (q.size() > 0 && q[0].is_i == h.is_i) void'(q.pop_front());
                if (tmo || h.last) begin
                    last_i = h.is_i;
                    gap = 1;
                    if (h.is_i) drop_i = 1; else drop_d = 1;
                end
                if (q.size() > 0) tgt = wait_for(q[0].is_i, iw, dw);
            end else if (exp_req) begin
                waited++;
            end
            guard++;
        end while ((q.size() > 0 || gap > 0) && guard < 400);
        i_ibus_req = 0; i_dbus_req = 0; i_mem_ack = 0;
        if (guard >= 400) begin
            vecs++; errs++; $display("FAIL round_bound: %0d beats still outstanding", q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge i_clock);
        i_reset = 1; i_mem_ack = 0; i_mem_rdata = 0;
        @(negedge i_clock);
        #1;
        vecs++;
        if (all_out !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        i_reset = 0;
        last_i = 1;
    endtask

    // Both sides held high from reset: expect D, I, D, I with one idle cycle between.
    task automatic test_continuous();
        int p; bit exp_req, exp_d; logic [31:0] exp_a;
        i_ibus_addr = 32'h2000; i_dbus_addr = 32'h100; i_dbus_we = 0; i_dbus_be = 4'hF;
        i_dbus_wdata = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge i_clock);
            i_ibus_req = (c < 14); i_dbus_req = (c < 14);
            i_mem_ack = 1; i_mem_rdata = $urandom;
            #1;
            p = (c >= 1) ? (c - 1) % 7 : 1;
            exp_req = (p != 1) && (p != 6);
            exp_d   = exp_req && (p == 0);
            exp_a   = exp_d ? 32'h100 : 32'h2000 + 32'(4 * (p - 2));
            vecs++;
            if (o_mem_req !== exp_req || (exp_req && o_mem_addr !== exp_a)) begin
                errs++;
                $display("FAIL continuous_grant c%0d: got req=%b addr=%h want req=%b addr=%h",
                         c, o_mem_req, o_mem_addr, exp_req, exp_a);
            end
            vecs++;
            if ({o_dbus_done, o_ibus_last} !== {exp_d, exp_req && p == 5}) begin
                errs++;
                $display("FAIL continuous_resp c%0d: got done/last=%b%b want %b%b",
                         c, o_dbus_done, o_ibus_last, exp_d, exp_req && p == 5);
            end
        end
        i_mem_ack = 0;
        last_i = 1;
    endtask

    task automatic test_idle_ack();
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clock);
            i_ibus_req = 0; i_dbus_req = 0; i_mem_ack = 1; i_mem_rdata = $urandom;
            #1;
            vecs++;
            if (pulses !== '0) begin
                errs++; $display("FAIL idle_ack: got pulses %b want 000000", pulses);
            end
        end
        i_mem_ack = 0;
    endtask

    task automatic test_data_write();
        do_round(0, 1, 32'h0, 32'h100, 1, 4'b0011, 32'hDEADBEEF, 0, 2);
    endtask

    task automatic test_refill();
        do_round(1, 0, 32'h1234, 32'h0, 0, 4'h0, 32'h0, 0, 0);
    endtask

    task automatic test_timeout();
        do_round(1, 1, 32'h3000, 32'h200, 0, 4'hF, 32'h0, 0, 20);
    endtask

    task automatic test_ack_at_timeout();
        do_round(0, 1, 32'h0, 32'h300, 0, 4'hF, 32'h0, 0, TO);
    endtask

    task automatic test_reset_mid();
        i_ibus_addr = 32'h4008;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clock);
            i_ibus_req = (c < 4); i_mem_ack = (c >= 1 && c < 4);
            i_mem_rdata = (c < 4) ? $urandom : 0;
            i_reset = (c == 3);
            #1;
            if (c == 3) begin
                vecs++;
                if ({o_ibus_rvalid, o_ibus_beat} !== 3'b110) begin
                    errs++; $display("FAIL reset_mid_beat: got rvalid/beat=%b/%0d want 1/2",
                                     o_ibus_rvalid, o_ibus_beat);
                end
            end
            if (c == 4) begin
                vecs++;
                if (all_out !== '0) begin
                    errs++; $display("FAIL reset_mid_outputs: got %h want 0", all_out);
                end
            end
        end
        i_mem_ack = 0;
        last_i = 1;
        do_round(1, 0, 32'h4008, 32'h0, 0, 4'h0, 32'h0, 0, 0);
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(1, 3);
            do_round(sel[0], sel[1], $urandom, $urandom, 1'($urandom_range(0, 1)),
                     4'($urandom), $urandom, -1, -1);
        end
    endtask

    initial begin
        i_reset = 1; i_ibus_req = 0; i_ibus_addr = 0; i_dbus_req = 0; i_dbus_we = 0;
        i_dbus_be = 0; i_dbus_addr = 0; i_dbus_wdata = 0; i_mem_ack = 0; i_mem_rdata = 0;
        test_reset();
        test_continuous();
        test_idle_ack();
        test_data_write();
        test_refill();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
